// File: rtl/biriscv_branch_arb_pkg.sv
// Shared definitions for the branch arbiter: resolve-record layout and helpers.
package biriscv_branch_arb_pkg;

  localparam int BRU_ENTRY_W = 68;

  // Resolve record as stored in the queue, MSB first: {taken,call,ret,jmp,source,pc}
  typedef struct packed {
    logic        taken;
    logic        call;
    logic        ret;
    logic        jmp;
    logic [31:0] source;
    logic [31:0] pc;
  } bru_entry_t;

  // Drop counter increment that sticks at all-ones instead of wrapping
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {15'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/biriscv_branch_arb_if.sv
// Branch-predictor update port: queue head plus accept handshake.
interface biriscv_branch_arb_if;
  logic        upd_valid_o;
  logic        upd_ready_i;
  logic        upd_taken_o;
  logic [31:0] upd_source_o;
  logic [31:0] upd_pc_o;
  logic        upd_call_o;
  logic        upd_ret_o;
  logic        upd_jmp_o;

  modport master (
    output upd_valid_o, upd_taken_o, upd_source_o, upd_pc_o,
           upd_call_o, upd_ret_o, upd_jmp_o,
    input  upd_ready_i
  );

  modport slave (
    input  upd_valid_o, upd_taken_o, upd_source_o, upd_pc_o,
           upd_call_o, upd_ret_o, upd_jmp_o,
    output upd_ready_i
  );
endinterface

// File: rtl/biriscv_branch_arb_fifo.sv
// Two-write / one-read resolve FIFO. Writes are pre-qualified by the caller;
// space_o reflects the registered count so a same-cycle pop never frees a slot.
module biriscv_branch_arb_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 68,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             wr0_i,
  input  logic [WIDTH-1:0] wr0_data_i,
  input  logic             wr1_i,
  input  logic [WIDTH-1:0] wr1_data_i,
  input  logic             rd_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             rd_valid_o,
  output logic [CNT_W-1:0] space_o,
  output logic [CNT_W-1:0] count_next_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_rd;
  logic [CNT_W-1:0] wr_cnt;

  // Pointer/count next state; a flush empties the queue and ignores this cycle's traffic
  always_comb begin
    do_rd  = rd_i && (count_q != '0);
    wr_cnt = CNT_W'(wr0_i) + CNT_W'(wr1_i);
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + wr_cnt[PTR_W-1:0];
      rd_ptr_d = rd_ptr_q + PTR_W'(do_rd);
      count_d  = count_q + wr_cnt - CNT_W'(do_rd);
    end
  end

  // Control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage: the older record always lands in the first free slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (!flush_i) begin
      if (wr0_i || wr1_i) mem_q[wr_ptr_q] <= wr0_i ? wr0_data_i : wr1_data_i;
      if (wr0_i && wr1_i) mem_q[wr_ptr_q + PTR_W'(1)] <= wr1_data_i;
    end
  end

  assign rd_data_o    = mem_q[rd_ptr_q];
  assign rd_valid_o   = (count_q != '0);
  assign space_o      = CNT_W'(DEPTH) - count_q;
  assign count_next_o = count_d;

endmodule

// File: rtl/biriscv_branch_arb.sv
// Branch outcome arbiter: lane0-priority early redirect with a shadow window,
// plus an ordered resolve queue draining to the predictor update port.
module biriscv_branch_arb
  import biriscv_branch_arb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int SHADOW = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  input  logic        l0_redirect_i,
  input  logic [31:0] l0_redirect_pc_i,
  input  logic        l1_redirect_i,
  input  logic [31:0] l1_redirect_pc_i,
  input  logic        l0_req_i,
  input  logic        l0_taken_i,
  input  logic [31:0] l0_source_i,
  input  logic [31:0] l0_pc_i,
  input  logic        l0_call_i,
  input  logic        l0_ret_i,
  input  logic        l0_jmp_i,
  input  logic        l1_req_i,
  input  logic        l1_taken_i,
  input  logic [31:0] l1_source_i,
  input  logic [31:0] l1_pc_i,
  input  logic        l1_call_i,
  input  logic        l1_ret_i,
  input  logic        l1_jmp_i,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
  biriscv_branch_arb_if.master upd,
  output logic        stall_o,
  output logic [15:0] drop_cnt_o
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic        redirect_q, redirect_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic [2:0]  shadow_q, shadow_d;
  logic [15:0] drop_q, drop_d;
  logic        stall_q, stall_d;

  logic             redir_acc;
  logic             push0, push1, pop;
  logic [1:0]       ndrop;
  logic [CNT_W-1:0] space, count_next;
  bru_entry_t       e0, e1, head;
  logic             head_valid;

  // Redirect select, shadow window, queue admission and drop accounting
  always_comb begin
    e0 = '{taken: l0_taken_i, call: l0_call_i, ret: l0_ret_i, jmp: l0_jmp_i,
           source: l0_source_i, pc: l0_pc_i};
    e1 = '{taken: l1_taken_i, call: l1_call_i, ret: l1_ret_i, jmp: l1_jmp_i,
           source: l1_source_i, pc: l1_pc_i};

    redir_acc     = (l0_redirect_i || l1_redirect_i) && (shadow_q == '0) && !flush_i;
    redirect_d    = redir_acc;
    redirect_pc_d = redirect_pc_q;
    if (redir_acc) redirect_pc_d = l0_redirect_i ? l0_redirect_pc_i : l1_redirect_pc_i;

    if (flush_i)             shadow_d = '0;
    else if (redir_acc)      shadow_d = 3'(SHADOW);
    else if (shadow_q != '0) shadow_d = shadow_q - 3'd1;
    else                     shadow_d = '0;

    // lane1 only gets a slot left over after lane0 has claimed one
    push0 = l0_req_i && !flush_i && (space != '0);
    push1 = l1_req_i && !flush_i && (space > CNT_W'(l0_req_i));
    pop   = head_valid && upd.upd_ready_i;

    ndrop = '0;
    if (!flush_i) ndrop = 2'(l0_req_i && !push0) + 2'(l1_req_i && !push1);
    drop_d  = sat_add16(drop_q, ndrop);
    stall_d = (CNT_W'(DEPTH) - count_next) < CNT_W'(2);
  end

  // Control registers, all cleared by the asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      shadow_q      <= '0;
      drop_q        <= '0;
      stall_q       <= 1'b0;
    end else begin
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      shadow_q      <= shadow_d;
      drop_q        <= drop_d;
      stall_q       <= stall_d;
    end
  end

  biriscv_branch_arb_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(BRU_ENTRY_W)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush_i),
    .wr0_i        (push0),
    .wr0_data_i   (e0),
    .wr1_i        (push1),
    .wr1_data_i   (e1),
    .rd_i         (pop),
    .rd_data_o    (head),
    .rd_valid_o   (head_valid),
    .space_o      (space),
    .count_next_o (count_next)
  );

  assign redirect_o       = redirect_q;
  assign redirect_pc_o    = redirect_pc_q;
  assign stall_o          = stall_q;
  assign drop_cnt_o       = drop_q;
  assign upd.upd_valid_o  = head_valid;
  assign upd.upd_taken_o  = head.taken;
  assign upd.upd_call_o   = head.call;
  assign upd.upd_ret_o    = head.ret;
  assign upd.upd_jmp_o    = head.jmp;
  assign upd.upd_source_o = head.source;
  assign upd.upd_pc_o     = head.pc;

endmodule

// File: tb/tb_biriscv_branch_arb.sv
// Directed bench for biriscv_branch_arb with a queue-based reference model.
module tb_biriscv_branch_arb;
  localparam int DEPTH  = 4;
  localparam int SHADOW = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush;
  logic        r0, r1, q0, q1;
  logic [31:0] p0, p1, s0, s1;
  logic        redirect_o, stall_o;
  logic [31:0] redirect_pc_o;
  logic [15:0] drop_cnt_o;

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;

  biriscv_branch_arb_if upd_if ();

  always #5 clk = ~clk;

  biriscv_branch_arb #(.DEPTH(DEPTH), .SHADOW(SHADOW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .flush_i          (flush),
    .l0_redirect_i    (r0),
    .l0_redirect_pc_i (p0),
    .l1_redirect_i    (r1),
    .l1_redirect_pc_i (p1),
    .l0_req_i         (q0),
    .l0_taken_i       (s0[4]),
    .l0_source_i      (s0),
    .l0_pc_i          (s0 + 32'd4),
    .l0_call_i        (s0[5]),
    .l0_ret_i         (s0[6]),
    .l0_jmp_i         (s0[7]),
    .l1_req_i         (q1),
    .l1_taken_i       (s1[4]),
    .l1_source_i      (s1),
    .l1_pc_i          (s1 + 32'd4),
    .l1_call_i        (s1[5]),
    .l1_ret_i         (s1[6]),
    .l1_jmp_i         (s1[7]),
    .redirect_o       (redirect_o),
    .redirect_pc_o    (redirect_pc_o),
    .upd              (upd_if),
    .stall_o          (stall_o),
    .drop_cnt_o       (drop_cnt_o)
  );

  // Record image {taken,call,ret,jmp,source,pc} for a branch at PC s
  function automatic logic [67:0] ent(input logic [31:0] s);
    return {s[4], s[5], s[6], s[7], s, s + 32'd4};
  endfunction

  task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: records in a plain queue, counters as integers
  logic [67:0] mq[$];
  logic [67:0] nw[$];
  logic        m_redir;
  logic [31:0] m_pc;
  int          m_shadow, m_drop, m_free;
  logic        m_stall;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete(); m_redir = 0; m_pc = 0; m_shadow = 0; m_drop = 0; m_stall = 0;
    end else if (flush) begin
      mq.delete(); m_redir = 0; m_shadow = 0; m_stall = 0;
    end else begin
      nw.delete();
      m_free = DEPTH - mq.size();
      if (q0) begin
        if (m_free > 0) begin nw.push_back(ent(s0)); m_free--; end else m_drop++;
      end
      if (q1) begin
        if (m_free > 0) begin nw.push_back(ent(s1)); m_free--; end else m_drop++;
      end
      if (m_drop > 65535) m_drop = 65535;
      if (mq.size() > 0 && upd_if.upd_ready_i) void'(mq.pop_front());
      foreach (nw[i]) mq.push_back(nw[i]);
      if (m_shadow == 0 && (r0 || r1)) begin
        m_redir = 1; m_pc = r0 ? p0 : p1; m_shadow = SHADOW;
      end else begin
        m_redir = 0;
        if (m_shadow > 0) m_shadow--;
      end
      m_stall = (DEPTH - mq.size()) < 2;
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (mon_en) begin
      chk("redirect_o", 68'(redirect_o), 68'(m_redir));
      chk("redirect_pc_o", 68'(redirect_pc_o), 68'(m_pc));
      chk("upd_valid_o", 68'(upd_if.upd_valid_o), 68'(mq.size() != 0));
      if (mq.size() != 0)
        chk("upd_head", {upd_if.upd_taken_o, upd_if.upd_call_o, upd_if.upd_ret_o,
                         upd_if.upd_jmp_o, upd_if.upd_source_o, upd_if.upd_pc_o}, mq[0]);
      chk("stall_o", 68'(stall_o), 68'(m_stall));
      chk("drop_cnt_o", 68'(drop_cnt_o), 68'(m_drop));
    end
  end

  task automatic step(input logic ar0, input logic [31:0] ap0, input logic ar1, input logic [31:0] ap1,
                      input logic aq0, input logic [31:0] as0, input logic aq1, input logic [31:0] as1,
                      input logic ardy, input logic afl);
    r0 = ar0; p0 = ap0; r1 = ar1; p1 = ap1;
    q0 = aq0; s0 = as0; q1 = aq1; s1 = as1;
    upd_if.upd_ready_i = ardy; flush = afl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ardy);
    step(0, 0, 0, 0, 0, 0, 0, 0, ardy, 0);
  endtask

  initial begin
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;
    chk("reset_redirect", 68'(redirect_o), 68'd0);
    chk("reset_valid", 68'(upd_if.upd_valid_o), 68'd0);
    chk("reset_stall", 68'(stall_o), 68'd0);
    chk("reset_drop", 68'(drop_cnt_o), 68'd0);

    // both lanes redirect: lane0 wins, single pulse
    step(1, 32'h100, 1, 32'h200, 0, 0, 0, 0, 0, 0);
    chk("t1_redirect", 68'(redirect_o), 68'd1);
    chk("t1_pc", 68'(redirect_pc_o), 68'h100);
    idle(0);
    chk("t1_pulse", 68'(redirect_o), 68'd0);
    chk("t1_pc_hold", 68'(redirect_pc_o), 68'h100);

    // shadow window swallows the back-to-back redirect
    step(1, 32'h300, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t2_first", 68'(redirect_pc_o), 68'h300);
    step(0, 0, 1, 32'h400, 0, 0, 0, 0, 0, 0);
    chk("t2_shadowed", 68'(redirect_o), 68'd0);
    step(0, 0, 1, 32'h500, 0, 0, 0, 0, 0, 0);
    chk("t2_after", 68'(redirect_o), 68'd1);
    chk("t2_after_pc", 68'(redirect_pc_o), 68'h500);
    idle(0);

    // overflow with the predictor stalled
    step(0, 0, 0, 0, 1, 32'h10, 1, 32'h20, 0, 0);
    chk("t3_stall_c1", 68'(stall_o), 68'd0);
    step(0, 0, 0, 0, 1, 32'h30, 1, 32'h40, 0, 0);
    chk("t3_stall_c2", 68'(stall_o), 68'd1);
    step(0, 0, 0, 0, 1, 32'h50, 1, 32'h60, 0, 0);
    chk("t3_drop", 68'(drop_cnt_o), 68'd2);
    chk("t3_head", 68'(upd_if.upd_source_o), 68'h10);

    // full queue: pop and push together, push still dropped
    step(0, 0, 0, 0, 1, 32'h70, 0, 0, 1, 0);
    chk("t4_drop", 68'(drop_cnt_o), 68'd3);
    chk("t4_head", 68'(upd_if.upd_source_o), 68'h20);
    chk("t4_stall", 68'(stall_o), 68'd1);
    idle(1);
    chk("t4_order1", 68'(upd_if.upd_source_o), 68'h30);
    idle(1);
    chk("t4_order2", 68'(upd_if.upd_source_o), 68'h40);
    chk("t4_pc", 68'(upd_if.upd_pc_o), 68'h44);
    idle(1);
    chk("t4_empty", 68'(upd_if.upd_valid_o), 68'd0);

    // flush with three queued and a redirect requested
    step(0, 0, 0, 0, 1, 32'h80, 1, 32'h90, 0, 0);
    step(1, 32'h600, 0, 0, 1, 32'hA0, 0, 0, 0, 0);
    chk("t5_redirect", 68'(redirect_pc_o), 68'h600);
    step(1, 32'h700, 0, 0, 1, 32'hB0, 0, 0, 0, 1);
    chk("t5_valid", 68'(upd_if.upd_valid_o), 68'd0);
    chk("t5_redirect_cancel", 68'(redirect_o), 68'd0);
    chk("t5_pc_hold", 68'(redirect_pc_o), 68'h600);
    chk("t5_drop", 68'(drop_cnt_o), 68'd3);
    step(0, 0, 1, 32'h800, 0, 0, 0, 0, 0, 0);
    chk("t5_post_flush", 68'(redirect_pc_o), 68'h800);
    idle(0);

    // asynchronous reset mid-cycle
    step(1, 32'h900, 0, 0, 1, 32'hC0, 1, 32'hD0, 0, 0);
    chk("t6_pre_valid", 68'(upd_if.upd_valid_o), 68'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_redirect", 68'(redirect_o), 68'd0);
    chk("t6_pc", 68'(redirect_pc_o), 68'd0);
    chk("t6_valid", 68'(upd_if.upd_valid_o), 68'd0);
    chk("t6_source", 68'(upd_if.upd_source_o), 68'd0);
    chk("t6_stall", 68'(stall_o), 68'd0);
    chk("t6_drop", 68'(drop_cnt_o), 68'd0);
    idle(0);
    rst_n = 1'b1;

    // drop counter saturation
    for (int i = 0; i < 32800; i++) step(0, 0, 0, 0, 1, 32'hE0, 1, 32'hF0, 0, 0);
    chk("sat_drop", 68'(drop_cnt_o), 68'hFFFF);
    idle(0);

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
